regfile_sb: RTL and testbench

Parametrised general-purpose register file for the datapath, with synchronous write, two combinational read ports, hardwired zero register and a per-register pending-write scoreboard. Decode reads operands and marks destinations pending at issue; writeback writes results and clears pending. Contents are zero after reset; no file preload.

---
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              lock_en,
   input  logic [ADDR_W-1:0] lock_addr,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] bank_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
   logic              wr_ok, lock_ok, cnt_inc, cnt_dec;

   // Accesses to a hardwired zero register are dropped before touching any state.
   assign wr_ok   = wr_en   && !(ZERO_REG && (wr_addr == '0));
   assign lock_ok = lock_en && !(ZERO_REG && (lock_addr == '0));

   always_comb begin
      pend_d = pend_q;
      if (wr_ok) pend_d[wr_addr] = 1'b0;
      if (lock_ok) pend_d[lock_addr] = 1'b1;
   end

   // Lock of the register being written re-arms it, so that write never decrements.
   assign cnt_inc = lock_ok && !pend_q[lock_addr];
   assign cnt_dec = wr_ok && pend_q[wr_addr] && !(lock_ok && (lock_addr == wr_addr));

   always_comb begin
      pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         if (wr_ok) bank_q[wr_addr] <= wr_data;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt = pend_cnt_q;

   always_comb begin
      rd_data1 = bank_q[rd_addr1];
      rd_busy1 = pend_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr1) && !(lock_ok && (lock_addr == rd_addr1))) begin
         rd_data1 = wr_data;
         rd_busy1 = 1'b0;
      end
`endif
      if (rst || (ZERO_REG && (rd_addr1 == '0))) begin
         rd_data1 = '0;
         rd_busy1 = 1'b0;
      end
   end

   always_comb begin
      rd_data2 = bank_q[rd_addr2];
      rd_busy2 = pend_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr2) && !(lock_ok && (lock_addr == rd_addr2))) begin
         rd_data2 = wr_data;
         rd_busy2 = 1'b0;
      end
`endif
      if (rst || (ZERO_REG && (rd_addr2 == '0))) begin
         rd_data2 = '0;
         rd_busy2 = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default instance plus a small
// ADDR_W=3 instance for scoreboard saturation.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr1, rd_addr2, wr_addr, lock_addr;
   logic [31:0] rd_data1, rd_data2, wr_data;
   logic        rd_busy1, rd_busy2, wr_en, lock_en;
   logic [5:0]  pend_cnt;

   logic [2:0]  s_rd_addr1, s_rd_addr2, s_wr_addr, s_lock_addr;
   logic [7:0]  s_rd_data1, s_rd_data2, s_wr_data;
   logic        s_rd_busy1, s_rd_busy2, s_wr_en, s_lock_en;
   logic [3:0]  s_pend_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_sb u_dut (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .lock_en(lock_en), .lock_addr(lock_addr),
      .pend_cnt(pend_cnt)
   );

   regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) u_small (
      .clk(clk), .rst(rst),
      .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
      .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
      .rd_busy1(s_rd_busy1), .rd_busy2(s_rd_busy2),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .lock_en(s_lock_en), .lock_addr(s_lock_addr),
      .pend_cnt(s_pend_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply the currently driven strobes at the next rising edge, then settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      rd_addr1 = '0; rd_addr2 = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      lock_en = 1'b0; lock_addr = '0;
      s_rd_addr1 = '0; s_rd_addr2 = '0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
      s_lock_en = 1'b0; s_lock_addr = '0;
      #1 rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      rd_addr1 = 5'd5; rd_addr2 = 5'd7;
      #1;
      check("reset_cnt", pend_cnt, 0);
      check("reset_data1", rd_data1, 0);
      check("reset_busy2", rd_busy2, 0);

      // Plain write then read on both ports
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      step();
      wr_en = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
      #1;
      check("wr_r5_p1", rd_data1, 32'hDEADBEEF);
      check("wr_r5_p2", rd_data2, 32'hDEADBEEF);
      check("wr_r5_busy", rd_busy1, 0);

      // Zero register ignores write and lock
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      lock_en = 1'b1; lock_addr = 5'd0;
      step();
      wr_en = 1'b0; lock_en = 1'b0; rd_addr1 = 5'd0;
      #1;
      check("r0_data", rd_data1, 0);
      check("r0_busy", rd_busy1, 0);
      check("r0_cnt", pend_cnt, 0);

      // Scoreboard lock / clear
      lock_en = 1'b1; lock_addr = 5'd7;
      step();
      #1 check("lock7_cnt", pend_cnt, 1);
      lock_addr = 5'd9;
      step();
      lock_en = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd9;
      #1;
      check("lock9_cnt", pend_cnt, 2);
      check("r7_busy", rd_busy1, 1);
      check("r9_busy", rd_busy2, 1);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
      step();
      wr_en = 1'b0;
      #1;
      check("wr7_busy", rd_busy1, 0);
      check("wr7_cnt", pend_cnt, 1);
      check("wr7_data", rd_data1, 32'h55);

      // Same-address lock and write: lock wins
      lock_en = 1'b1; lock_addr = 5'd3;
      step();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
      step();
      wr_en = 1'b0; lock_en = 1'b0; rd_addr1 = 5'd3;
      #1;
      check("lw3_data", rd_data1, 32'hA5);
      check("lw3_busy", rd_busy1, 1);
      check("lw3_cnt", pend_cnt, 2);

      // Lock r4 while retiring pending r6: net zero
      lock_en = 1'b1; lock_addr = 5'd6;
      step();
      #1 check("lock6_cnt", pend_cnt, 3);
      lock_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
      step();
      wr_en = 1'b0; lock_en = 1'b0; rd_addr1 = 5'd4; rd_addr2 = 5'd6;
      #1;
      check("l4w6_cnt", pend_cnt, 3);
      check("l4_busy", rd_busy1, 1);
      check("w6_busy", rd_busy2, 0);

      // Relock of an already pending register
      lock_en = 1'b1; lock_addr = 5'd9;
      step();
      lock_en = 1'b0;
      #1 check("relock9_cnt", pend_cnt, 3);

      // Same-cycle read of a register being written
      lock_en = 1'b1; lock_addr = 5'd8;
      step();
      lock_en = 1'b0; rd_addr1 = 5'd8;
      #1 check("lock8_cnt", pend_cnt, 4);
      wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hCAFE;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_data", rd_data1, 32'hCAFE);
      check("byp_busy", rd_busy1, 0);
`else
      check("nobyp_data", rd_data1, 0);
      check("nobyp_busy", rd_busy1, 1);
`endif
      step();
      wr_en = 1'b0;
      #1;
      check("w8_data", rd_data1, 32'hCAFE);
      check("w8_busy", rd_busy1, 0);
      check("w8_cnt", pend_cnt, 3);

      // Write with a same-address lock must not forward
      wr_en = 1'b1; wr_data = 32'hBEEF; lock_en = 1'b1; lock_addr = 5'd8;
      #1;
      check("lwbyp_data", rd_data1, 32'hCAFE);
      check("lwbyp_busy", rd_busy1, 0);
      step();
      wr_en = 1'b0; lock_en = 1'b0;
      #1;
      check("lw8_data", rd_data1, 32'hBEEF);
      check("lw8_busy", rd_busy1, 1);
      check("lw8_cnt", pend_cnt, 4);

      // Asynchronous reset mid-cycle
      rd_addr1 = 5'd5; rd_addr2 = 5'd3;
      #1 rst = 1'b1;
      #1;
      check("arst_data1", rd_data1, 0);
      check("arst_busy2", rd_busy2, 0);
      check("arst_cnt", pend_cnt, 0);
      step();
      rst = 1'b0;
      #1;
      check("post_rst_data", rd_data1, 0);
      check("post_rst_busy", rd_busy2, 0);

      // Saturation on the small instance
      s_lock_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_lock_addr = 3'(i);
         step();
      end
      s_lock_en = 1'b0;
      #1 check("sat_cnt", s_pend_cnt, 7);
      s_rd_addr1 = 3'd7;
      #1 check("sat_busy7", s_rd_busy1, 1);
      s_wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_wr_addr = 3'(i);
         s_wr_data = 8'(8'h10 + i);
         step();
      end
      s_wr_en = 1'b0;
      s_rd_addr1 = 3'd6; s_rd_addr2 = 3'd0;
      #1;
      check("drain_cnt", s_pend_cnt, 0);
      check("drain_data6", s_rd_data1, 8'h16);
      check("drain_r0", s_rd_data2, 0);
      s_wr_en = 1'b1; s_wr_addr = 3'd2; s_wr_data = 8'h22;
      step();
      s_wr_en = 1'b0;
      #1 check("no_underflow", s_pend_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
